// File: rtl/axi_master_burst.sv
// Single-outstanding AXI master: turns one command into a full read or write burst,
// streaming beats to/from a valid/ready user port and pulsing done with the worst response.
module axi_master_burst #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic [1:0]        cmd_burst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        rd_resp,
    output logic              rd_last,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              done,
    output logic [1:0]        done_resp,
    output logic              len_err,
    output logic [ADDR_W-1:0] araddr,
    output logic [LEN_W-1:0]  arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [LEN_W-1:0]  awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    // state | meaning
    // IDLE  | waiting for a command      RADDR/WADDR | address phase, held until ready
    // RDATA | streaming read beats        WDATA | streaming write beats    WRESP | waiting for B
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [1:0]        worst;
    logic [1:0]        worst_next;
    logic              cnt_at_len;
    logic              w_hs;
    logic              r_hs;

    assign cnt_at_len = (cnt == len_q);
    assign w_hs       = (state == WDATA) && wr_valid && wready;
    assign r_hs       = (state == RDATA) && rvalid && rd_ready;
    assign worst_next = (rresp > worst) ? rresp : worst;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt       <= '0;
            worst     <= '0;
            done      <= 1'b0;
            done_resp <= '0;
            len_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            len_err <= 1'b0;
            case (state)
                IDLE: begin
                    // cmd_ready rises one clock after reset so a command held across release waits
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        addr_q    <= cmd_addr;
                        len_q     <= cmd_len;
                        size_q    <= cmd_size;
                        burst_q   <= cmd_burst;
                        cnt       <= '0;
                        worst     <= '0;
                        cmd_ready <= 1'b0;
                        state     <= cmd_write ? WADDR : RADDR;
                    end
                end
                RADDR: if (arready) state <= RDATA;
                WADDR: if (awready) state <= WDATA;
                WDATA: begin
                    if (w_hs) begin
                        cnt <= cnt + LEN_W'(1);
                        if (cnt_at_len) state <= WRESP;
                    end
                end
                WRESP: begin
                    if (bvalid) begin
                        done      <= 1'b1;
                        done_resp <= bresp;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                RDATA: begin
                    if (r_hs) begin
                        cnt   <= cnt + LEN_W'(1);
                        worst <= worst_next;
                        // a slave rlast and our own beat count both end the burst; disagreement is flagged
                        if (rlast || cnt_at_len) begin
                            done      <= 1'b1;
                            done_resp <= worst_next;
                            len_err   <= (rlast != cnt_at_len);
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign arvalid  = (state == RADDR);
    assign araddr   = addr_q;
    assign arlen    = len_q;
    assign arsize   = size_q;
    assign arburst  = burst_q;

    assign awvalid  = (state == WADDR);
    assign awaddr   = addr_q;
    assign awlen    = len_q;
    assign awsize   = size_q;
    assign awburst  = burst_q;

    assign wvalid   = (state == WDATA) && wr_valid;
    assign wdata    = wr_data;
    assign wlast    = (state == WDATA) && cnt_at_len;
    assign wr_ready = (state == WDATA) && wready;

    assign rready   = (state == RDATA) && rd_ready;
    assign rd_valid = (state == RDATA) && rvalid;
    assign rd_data  = rdata;
    assign rd_resp  = rresp;
    assign rd_last  = (state == RDATA) && rlast;

    assign bready   = (state == WRESP);

endmodule

// File: tb/tb_axi_master_burst.sv
// Directed bench for axi_master_burst: a bus engine plays user and AXI slave,
// scenario tasks compare recorded traffic against hand-computed values.
module tb_axi_master_burst;

    logic        aclk, areset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        rd_last, rd_valid, rd_ready;
    logic        done;
    logic [1:0]  done_resp;
    logic        len_err;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    axi_master_burst #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .done(done), .done_resp(done_resp), .len_err(len_err),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    // engine configuration
    int          n_cmd;
    logic        c_write [2];
    logic [31:0] c_addr  [2];
    logic [7:0]  c_len   [2];
    int          aw_delay, ar_delay, rlast_pos, err_beat;
    bit          wready_alt, rdready_tog;
    logic [1:0]  bresp_cfg;

    // engine observations
    int          cyc, aw_cnt, ar_cnt, wb, rb, done_cnt;
    logic [31:0] w_data_q [$];
    logic        w_last_q [$];
    logic [31:0] r_data_q [$];
    logic        r_last_q [$];
    logic [1:0]  r_resp_q [$];
    logic [1:0]  d_resp_q [$];
    logic        d_lerr_q [$];
    int          acc_q [$];
    int          done_q [$];
    bit          overlap, early_w, unstable, timeout;
    logic [31:0] last_awaddr, last_araddr;
    logic [7:0]  last_awlen, last_arlen;

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0;
        wr_data = 0; wr_valid = 0; rd_ready = 0;
        arready = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
    endtask

    task automatic cfg(input int n, input int awd, input int ard, input bit walt,
                       input bit rtog, input int rlp, input int errb, input logic [1:0] br);
        n_cmd = n; aw_delay = awd; ar_delay = ard; wready_alt = walt; rdready_tog = rtog;
        rlast_pos = rlp; err_beat = errb; bresp_cfg = br;
    endtask

    // Plays user and slave from a negedge; inputs driven at the negedge, outputs sampled 1 ns later.
    task automatic run_bus(input int budget, input int abort_wb);
        int   aw_wait = 0, ar_wait = 0, wbi = 0, r_k = 0, cmd_idx = 0;
        bit   r_act = 0, b_pend = 0, aw_seen = 0, stop = 0;
        bit   aw_stall = 0, ar_stall = 0;
        logic [31:0] p_awaddr = 0, p_araddr = 0;
        cyc = 0; aw_cnt = 0; ar_cnt = 0; wb = 0; rb = 0; done_cnt = 0;
        w_data_q.delete(); w_last_q.delete(); r_data_q.delete(); r_last_q.delete();
        r_resp_q.delete(); d_resp_q.delete(); d_lerr_q.delete(); acc_q.delete(); done_q.delete();
        overlap = 0; early_w = 0; unstable = 0; timeout = 0;
        while (!stop) begin
            cmd_valid = (cmd_idx < n_cmd);
            if (cmd_idx < n_cmd) begin
                cmd_write = c_write[cmd_idx]; cmd_addr = c_addr[cmd_idx]; cmd_len = c_len[cmd_idx];
            end
            cmd_size = 3'd2; cmd_burst = 2'd1;
            awready  = awvalid && (aw_wait >= aw_delay);
            arready  = arvalid && (ar_wait >= ar_delay);
            wready   = wready_alt ? cyc[0] : 1'b1;
            wr_valid = 1'b1;
            wr_data  = 32'hA0 + wbi;
            rvalid   = r_act;
            rdata    = 32'hA0 + r_k;
            rlast    = r_act && (r_k == rlast_pos);
            rresp    = (r_act && r_k == err_beat) ? 2'd2 : 2'd0;
            rd_ready = rdready_tog ? ~cyc[0] : 1'b1;
            bvalid   = b_pend;
            bresp    = bresp_cfg;
            #1;
            if (awvalid && arvalid) overlap = 1;
            if (aw_stall && (!awvalid || awaddr !== p_awaddr)) unstable = 1;
            if (ar_stall && (!arvalid || araddr !== p_araddr)) unstable = 1;
            aw_stall = awvalid && !awready; p_awaddr = awaddr;
            ar_stall = arvalid && !arready; p_araddr = araddr;
            if (cmd_valid && cmd_ready) begin acc_q.push_back(cyc); cmd_idx++; end
            if (wvalid && !aw_seen) early_w = 1;
            if (awvalid) begin
                if (awready) begin
                    aw_cnt++; aw_seen = 1; aw_wait = 0;
                    last_awaddr = awaddr; last_awlen = awlen;
                end else aw_wait++;
            end
            if (arvalid) begin
                if (arready) begin
                    ar_cnt++; ar_wait = 0; r_act = 1; r_k = 0;
                    last_araddr = araddr; last_arlen = arlen;
                end else ar_wait++;
            end
            if (wvalid && wready) begin
                w_data_q.push_back(wdata); w_last_q.push_back(wlast);
                wb++; wbi++;
                if (wlast) begin b_pend = 1; aw_seen = 0; wbi = 0; end
            end
            if (rd_valid && rd_ready) begin
                r_data_q.push_back(rd_data); r_last_q.push_back(rd_last); r_resp_q.push_back(rd_resp);
                rb++;
            end
            if (rvalid && rready) begin
                if (rlast) r_act = 0;
                r_k++;
            end
            if (bvalid && bready) b_pend = 0;
            if (done) begin
                done_cnt++; d_resp_q.push_back(done_resp); d_lerr_q.push_back(len_err);
                done_q.push_back(cyc);
            end
            if (done_cnt >= n_cmd) stop = 1;
            if (abort_wb >= 0 && wb >= abort_wb) stop = 1;
            cyc++;
            if (!stop && cyc >= budget) begin timeout = 1; stop = 1; end
            if (!stop) @(negedge aclk);
        end
        if (abort_wb < 0) begin
            idle_inputs();
            @(negedge aclk);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        areset_n = 0;
        #2;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%0b exp=0", cmd_ready); end
        total++; if ({arvalid, awvalid, wvalid, rready, bready, wr_ready, rd_valid} !== 7'b0) begin bad++; $display("FAIL rst_handshakes got=%b exp=0", {arvalid, awvalid, wvalid, rready, bready, wr_ready, rd_valid}); end
        total++; if ({done, len_err, done_resp} !== 4'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", {done, len_err, done_resp}); end
        total++; if ({awaddr, awlen} !== 40'h0) begin bad++; $display("FAIL rst_fields got=%h exp=0", {awaddr, awlen}); end
        @(negedge aclk);
        @(negedge aclk);
        // release reset together with a write command; it must not be taken on that edge
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_len = 8'd0;
        areset_n = 1;
        @(negedge aclk);
        total++; if (cmd_ready !== 1'b1 || awvalid !== 1'b0) begin bad++; $display("FAIL rst_release_cmd got=rdy%0b aw%0b exp=rdy1 aw0", cmd_ready, awvalid); end
        cmd_valid = 0;
        @(negedge aclk);
        total++; if (awvalid !== 1'b0) begin bad++; $display("FAIL rst_no_accept got=%0b exp=0", awvalid); end
    endtask

    task automatic test_write_incr();
        cfg(1, 0, 0, 0, 0, 0, -1, 2'd0);
        c_write[0] = 1; c_addr[0] = 32'h0; c_len[0] = 8'd3;
        run_bus(200, -1);
        total++; if (timeout) begin bad++; $display("FAIL wr_timeout got=1 exp=0"); end
        total++; if (aw_cnt !== 1 || last_awaddr !== 32'h0 || last_awlen !== 8'd3) begin bad++; $display("FAIL wr_aw got=cnt%0d addr%0h len%0d exp=cnt1 addr0 len3", aw_cnt, last_awaddr, last_awlen); end
        total++; if (wb !== 4) begin bad++; $display("FAIL wr_beats got=%0d exp=4", wb); end
        for (int i = 0; i < 4; i++) begin
            total++; if (w_data_q[i] !== 32'hA0 + i || w_last_q[i] !== (i == 3)) begin bad++; $display("FAIL wr_beat%0d got=%h last%0b exp=%h last%0b", i, w_data_q[i], w_last_q[i], 32'hA0 + i, i == 3); end
        end
        total++; if (done_cnt !== 1 || d_resp_q[0] !== 2'd0) begin bad++; $display("FAIL wr_done got=cnt%0d resp%0d exp=cnt1 resp0", done_cnt, d_resp_q[0]); end
        total++; if (done_q[0] - acc_q[0] !== 7) begin bad++; $display("FAIL wr_latency got=%0d exp=7", done_q[0] - acc_q[0]); end
        total++; if (early_w || overlap) begin bad++; $display("FAIL wr_order got=early%0b ovl%0b exp=0", early_w, overlap); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL wr_done_pulse got=%0b exp=0", done); end
    endtask

    task automatic test_read_incr();
        cfg(1, 0, 0, 0, 0, 3, -1, 2'd0);
        c_write[0] = 0; c_addr[0] = 32'h0; c_len[0] = 8'd3;
        run_bus(200, -1);
        total++; if (timeout) begin bad++; $display("FAIL rd_timeout got=1 exp=0"); end
        total++; if (ar_cnt !== 1 || aw_cnt !== 0 || last_arlen !== 8'd3) begin bad++; $display("FAIL rd_ar got=ar%0d aw%0d len%0d exp=ar1 aw0 len3", ar_cnt, aw_cnt, last_arlen); end
        total++; if (rb !== 4) begin bad++; $display("FAIL rd_beats got=%0d exp=4", rb); end
        for (int i = 0; i < 4; i++) begin
            total++; if (r_data_q[i] !== 32'hA0 + i || r_last_q[i] !== (i == 3)) begin bad++; $display("FAIL rd_beat%0d got=%h last%0b exp=%h last%0b", i, r_data_q[i], r_last_q[i], 32'hA0 + i, i == 3); end
        end
        total++; if (done_cnt !== 1 || d_resp_q[0] !== 2'd0 || d_lerr_q[0] !== 1'b0) begin bad++; $display("FAIL rd_done got=cnt%0d resp%0d lerr%0b exp=cnt1 resp0 lerr0", done_cnt, d_resp_q[0], d_lerr_q[0]); end
        total++; if (done_q[0] - acc_q[0] !== 6) begin bad++; $display("FAIL rd_latency got=%0d exp=6", done_q[0] - acc_q[0]); end
    endtask

    task automatic test_backpressure();
        cfg(1, 3, 0, 1, 0, 0, -1, 2'd0);
        c_write[0] = 1; c_addr[0] = 32'h200; c_len[0] = 8'd3;
        run_bus(200, -1);
        total++; if (timeout || unstable) begin bad++; $display("FAIL bp_wr_flags got=to%0b unst%0b exp=0", timeout, unstable); end
        total++; if (wb !== 4 || aw_cnt !== 1) begin bad++; $display("FAIL bp_wr_counts got=w%0d aw%0d exp=w4 aw1", wb, aw_cnt); end
        for (int i = 0; i < 4; i++) begin
            total++; if (w_data_q[i] !== 32'hA0 + i || w_last_q[i] !== (i == 3)) begin bad++; $display("FAIL bp_wr_beat%0d got=%h last%0b exp=%h", i, w_data_q[i], w_last_q[i], 32'hA0 + i); end
        end
        total++; if (done_q[0] - acc_q[0] !== 13) begin bad++; $display("FAIL bp_wr_latency got=%0d exp=13", done_q[0] - acc_q[0]); end
        cfg(1, 0, 3, 0, 1, 3, -1, 2'd0);
        c_write[0] = 0; c_addr[0] = 32'h300; c_len[0] = 8'd3;
        run_bus(200, -1);
        total++; if (timeout || unstable) begin bad++; $display("FAIL bp_rd_flags got=to%0b unst%0b exp=0", timeout, unstable); end
        total++; if (rb !== 4 || last_araddr !== 32'h300) begin bad++; $display("FAIL bp_rd_counts got=r%0d addr%h exp=r4 addr300", rb, last_araddr); end
        for (int i = 0; i < 4; i++) begin
            total++; if (r_data_q[i] !== 32'hA0 + i) begin bad++; $display("FAIL bp_rd_beat%0d got=%h exp=%h", i, r_data_q[i], 32'hA0 + i); end
        end
        total++; if (done_q[0] - acc_q[0] !== 13) begin bad++; $display("FAIL bp_rd_latency got=%0d exp=13", done_q[0] - acc_q[0]); end
    endtask

    task automatic test_early_last();
        cfg(1, 0, 0, 0, 0, 2, 1, 2'd0);
        c_write[0] = 0; c_addr[0] = 32'h0; c_len[0] = 8'd3;
        run_bus(200, -1);
        total++; if (timeout || rb !== 3) begin bad++; $display("FAIL el_beats got=%0d to%0b exp=3", rb, timeout); end
        total++; if (r_resp_q[0] !== 2'd0 || r_resp_q[1] !== 2'd2 || r_last_q[2] !== 1'b1) begin bad++; $display("FAIL el_mirror got=resp%0d,%0d last%0b exp=resp0,2 last1", r_resp_q[0], r_resp_q[1], r_last_q[2]); end
        total++; if (d_resp_q[0] !== 2'd2 || d_lerr_q[0] !== 1'b1) begin bad++; $display("FAIL el_done got=resp%0d lerr%0b exp=resp2 lerr1", d_resp_q[0], d_lerr_q[0]); end
        // slave signals rlast too late: the beat count ends the burst
        cfg(1, 0, 0, 0, 0, 5, -1, 2'd0);
        run_bus(200, -1);
        total++; if (timeout || rb !== 4) begin bad++; $display("FAIL ll_beats got=%0d to%0b exp=4", rb, timeout); end
        total++; if (d_resp_q[0] !== 2'd0 || d_lerr_q[0] !== 1'b1) begin bad++; $display("FAIL ll_done got=resp%0d lerr%0b exp=resp0 lerr1", d_resp_q[0], d_lerr_q[0]); end
    endtask

    task automatic test_long_read();
        cfg(1, 0, 0, 0, 0, 255, -1, 2'd0);
        c_write[0] = 0; c_addr[0] = 32'h1000; c_len[0] = 8'd255;
        run_bus(600, -1);
        total++; if (timeout || rb !== 256) begin bad++; $display("FAIL long_beats got=%0d to%0b exp=256", rb, timeout); end
        total++; if (r_data_q[255] !== 32'h19F || d_lerr_q[0] !== 1'b0) begin bad++; $display("FAIL long_last got=%h lerr%0b exp=19f lerr0", r_data_q[255], d_lerr_q[0]); end
    endtask

    task automatic test_reset_mid_write();
        cfg(1, 0, 0, 0, 0, 0, -1, 2'd0);
        c_write[0] = 1; c_addr[0] = 32'h0; c_len[0] = 8'd3;
        run_bus(200, 2);
        total++; if (timeout || wb !== 2) begin bad++; $display("FAIL mr_beats got=%0d to%0b exp=2", wb, timeout); end
        @(posedge aclk);
        #2;
        areset_n = 0;
        #1;
        total++; if ({awvalid, wvalid, wlast, wr_ready, bready, arvalid, rready, rd_valid, cmd_ready, done, len_err} !== 11'b0) begin bad++; $display("FAIL mr_outputs got=%b exp=0", {awvalid, wvalid, wlast, wr_ready, bready, arvalid, rready, rd_valid, cmd_ready, done, len_err}); end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            total++; if (done !== 1'b0) begin bad++; $display("FAIL mr_no_done got=%0b exp=0", done); end
        end
        areset_n = 1;
        @(negedge aclk);
        total++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL mr_idle got=rdy%0b done%0b exp=rdy1 done0", cmd_ready, done); end
        c_addr[0] = 32'h100; c_len[0] = 8'd1;
        run_bus(200, -1);
        total++; if (timeout || wb !== 2 || last_awaddr !== 32'h100) begin bad++; $display("FAIL mr_restart got=w%0d addr%h exp=w2 addr100", wb, last_awaddr); end
        total++; if (w_last_q[0] !== 1'b0 || w_last_q[1] !== 1'b1 || w_data_q[0] !== 32'hA0) begin bad++; $display("FAIL mr_restart_beats got=last%0b%0b d%h exp=last01 dA0", w_last_q[0], w_last_q[1], w_data_q[0]); end
    endtask

    task automatic test_back_to_back();
        cfg(2, 0, 0, 0, 0, 1, -1, 2'd3);
        c_write[0] = 1; c_addr[0] = 32'h40; c_len[0] = 8'd1;
        c_write[1] = 0; c_addr[1] = 32'h80; c_len[1] = 8'd1;
        run_bus(200, -1);
        total++; if (timeout || done_cnt !== 2) begin bad++; $display("FAIL b2b_done_cnt got=%0d to%0b exp=2", done_cnt, timeout); end
        total++; if (acc_q[1] !== done_q[0]) begin bad++; $display("FAIL b2b_accept got=%0d exp=%0d", acc_q[1], done_q[0]); end
        total++; if (overlap || aw_cnt !== 1 || ar_cnt !== 1) begin bad++; $display("FAIL b2b_addr got=ovl%0b aw%0d ar%0d exp=ovl0 aw1 ar1", overlap, aw_cnt, ar_cnt); end
        total++; if (d_resp_q[0] !== 2'd3 || d_resp_q[1] !== 2'd0) begin bad++; $display("FAIL b2b_resp got=%0d,%0d exp=3,0", d_resp_q[0], d_resp_q[1]); end
        total++; if (wb !== 2 || rb !== 2 || last_araddr !== 32'h80) begin bad++; $display("FAIL b2b_beats got=w%0d r%0d addr%h exp=w2 r2 addr80", wb, rb, last_araddr); end
    endtask

    initial begin
        test_reset();
        test_write_incr();
        test_read_incr();
        test_backpressure();
        test_early_last();
        test_long_read();
        test_reset_mid_write();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
